enc_stream_ctrl: RTL and testbench
==================================

ENC_STREAM_CTRL -- requirements
Module: enc_stream_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_BLOCKS, default 1664, giving the number of public-key column blocks streamed per encryption (min 1).
REQ-002 The block SHALL have parameter COL_WIDTH, default 128, giving the public-key column block width in bits.
REQ-003 The block SHALL have parameter CIPHER_WORDS, default 39, giving the number of 32-bit ciphertext words read out (min 1).
REQ-004 The block SHALL have parameter TIMEOUT, default 65535, giving the cycle limit for the WAIT_DONE watchdog.
REQ-005 The block SHALL have a single clock and asynchronous active-low reset, on these ports: clk  in  1  clock; rst_n  in  1  reset.
REQ-006 The block SHALL have these host ports: start  in  1  begin-operation pulse; busy  out  1  operation in progress; err  out  1  protocol or timeout error, sticky until next start.
REQ-007 The block SHALL have these datapath control ports: enc_start  out  1  one-cycle start to encryptor; enc_k_ready  in  1  encryptor accepts key blocks; enc_done  in  1  encryption complete pulse.
REQ-008 The block SHALL have these key memory ports: key_addr  out  clog2(NUM_BLOCKS)  sync-read key memory address (1-cycle latency); key_col_valid  out  1  key memory output presented to encryptor.
REQ-009 The block SHALL have these ciphertext readout ports: c_rd_en  out  1; c_rd_addr  out  clog2(CIPHER_WORDS); c_data  in  32  ciphertext word (1-cycle latency); c_out  out  32; c_out_valid  out  1; c_out_ready  in  1.

Function
REQ-010 The FSM SHALL have these states: IDLE, KICK, WAIT_KRDY, STREAM, WAIT_DONE, RD_ISSUE, RD_HOLD, FINISH.
REQ-011 In IDLE, start=1 SHALL go to KICK and clear err; start SHALL be ignored in every other state.
REQ-012 KICK SHALL assert enc_start for exactly one cycle, then go to WAIT_KRDY.
REQ-013 WAIT_KRDY SHALL wait for enc_k_ready=1, then go to STREAM with rd_ptr=0, with key_addr=0 already issued and key_col_valid=1 from the next cycle.
REQ-014 In STREAM, a fire SHALL be key_col_valid & enc_k_ready, and key_addr SHALL equal rd_ptr+fire combinationally, so the word on the memory output is never lost while the encryptor stalls.
REQ-015 The block SHALL stream at full throughput: one block accepted per cycle while enc_k_ready=1, and key_col_valid SHALL stay high and rd_ptr SHALL hold while enc_k_ready=0.
REQ-016 When block NUM_BLOCKS-1 fires, key_col_valid SHALL drop the next cycle, key_addr SHALL not exceed NUM_BLOCKS-1, and the FSM SHALL go to WAIT_DONE.
REQ-017 enc_done=1 during WAIT_KRDY or STREAM SHALL set err and go to FINISH, skipping readout.
REQ-018 WAIT_DONE SHALL go to RD_ISSUE with word index 0 on enc_done=1.
REQ-019 RD_ISSUE SHALL pulse c_rd_en with c_rd_addr=index, then go to RD_HOLD; on the following cycle c_out SHALL capture c_data and c_out_valid SHALL be 1.
REQ-020 RD_HOLD SHALL hold c_out and c_out_valid until c_out_ready=1, and c_out SHALL not change while c_out_valid=1 & c_out_ready=0.
REQ-021 On acceptance in RD_HOLD, if index=CIPHER_WORDS-1 the FSM SHALL go to FINISH, else it SHALL increment index and return to RD_ISSUE, giving one word per 2 cycles maximum.
REQ-022 FINISH SHALL deassert busy and return to IDLE in one cycle.
REQ-023 busy SHALL be 1 in every state except IDLE.

Reset
REQ-024 On rst_n=0 the block SHALL asynchronously enter IDLE and set: busy=0, err=0, enc_start=0, key_addr=0, key_col_valid=0, c_rd_en=0, c_rd_addr=0, c_out=0, c_out_valid=0; counters and rd_ptr SHALL be 0.
REQ-025 Reset asserted mid-operation SHALL abandon the operation, with no pulse on enc_start or c_rd_en after reset release until a new start.

Configuration
REQ-026 With ENC_STREAM_TIMEOUT_EN defined, a counter SHALL run in WAIT_KRDY and WAIT_DONE, and reaching TIMEOUT cycles SHALL set err and go to FINISH.
REQ-027 Without ENC_STREAM_TIMEOUT_EN, no counter SHALL be synthesised, both states SHALL wait indefinitely, and err SHALL be set only per REQ-017.

Verification
REQ-028 NUM_BLOCKS=4, enc_k_ready always 1: start -> enc_start pulse, key_addr 0,1,2,3 issued on consecutive cycles, 4 fires, key_col_valid low after 4th.
REQ-029 NUM_BLOCKS=4, enc_k_ready low for 3 cycles after the 2nd fire -> key_col_valid held high, block 2 data unchanged, exactly 4 fires total in order 0..3.
REQ-030 CIPHER_WORDS=3, c_data=addr+0xA0, c_out_ready toggling -> c_out sequence 0xA0,0xA1,0xA2, each held while not ready, then busy=0.
REQ-031 enc_done pulsed during STREAM -> err=1, FINISH, no c_rd_en; next start -> err cleared.
REQ-032 rst_n pulled low during STREAM (block 2) -> all outputs 0 immediately, IDLE; new start -> full clean run.
REQ-033 ENC_STREAM_TIMEOUT_EN, TIMEOUT=100, enc_done never asserted -> err=1 exactly 100 cycles into WAIT_DONE; without the macro -> busy stays 1.

Source files
------------

// File: rtl/enc_stream_ctrl.sv
// Sequencer for one encryption: kicks the encryptor, streams key column blocks
// from a sync-read memory, waits for completion, then reads out the ciphertext.
// Optional watchdog on the wait states: define ENC_STREAM_TIMEOUT_EN.
module enc_stream_ctrl #(
  parameter int NUM_BLOCKS   = 1664,
  parameter int COL_WIDTH    = 128,
  parameter int CIPHER_WORDS = 39,
  parameter int TIMEOUT      = 65535,
  localparam int KAW = (NUM_BLOCKS > 1)   ? $clog2(NUM_BLOCKS)   : 1,
  localparam int CAW = (CIPHER_WORDS > 1) ? $clog2(CIPHER_WORDS) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           busy,
  output logic           err,
  output logic           enc_start,
  input  logic           enc_k_ready,
  input  logic           enc_done,
  output logic [KAW-1:0] key_addr,
  output logic           key_col_valid,
  output logic           c_rd_en,
  output logic [CAW-1:0] c_rd_addr,
  input  logic [31:0]    c_data,
  output logic [31:0]    c_out,
  output logic           c_out_valid,
  input  logic           c_out_ready
);

  if (NUM_BLOCKS < 1 || CIPHER_WORDS < 1 || COL_WIDTH < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("enc_stream_ctrl: illegal parameter value");
  end

  typedef enum logic [2:0] {
    IDLE, KICK, WAIT_KRDY, STREAM, WAIT_DONE, RD_ISSUE, RD_HOLD, FINISH
  } state_e;

  state_e         state_q, state_d;
  logic [KAW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CAW-1:0] idx_q, idx_d;
  logic           err_q, err_d;
  logic           fresh_q;
  logic [31:0]    c_out_q;
  logic           fire, last_blk, tmo_hit;

  assign fire     = (state_q == STREAM) && enc_k_ready;
  assign last_blk = (rd_ptr_q == KAW'(NUM_BLOCKS - 1));

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    idx_d    = idx_q;
    err_d    = err_q;
    key_addr = '0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = KICK;
        err_d   = 1'b0;
      end
      KICK: state_d = WAIT_KRDY;
      WAIT_KRDY: begin
        if (enc_done) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else if (enc_k_ready) begin
          state_d  = STREAM;
          rd_ptr_d = '0;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end
      end
      STREAM: begin
        // Address runs one ahead on a fire so the next block is already on the
        // memory output; on a stall it re-reads the block being presented.
        key_addr = (fire && !last_blk) ? rd_ptr_q + KAW'(1) : rd_ptr_q;
        if (enc_done) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else if (fire) begin
          if (last_blk) state_d = WAIT_DONE;
          else          rd_ptr_d = rd_ptr_q + KAW'(1);
        end
      end
      WAIT_DONE: begin
        if (enc_done) begin
          state_d = RD_ISSUE;
          idx_d   = '0;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end
      end
      RD_ISSUE: state_d = RD_HOLD;
      RD_HOLD: if (c_out_ready) begin
        if (idx_q == CAW'(CIPHER_WORDS - 1)) begin
          state_d = FINISH;
        end else begin
          idx_d   = idx_q + CAW'(1);
          state_d = RD_ISSUE;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      fresh_q  <= 1'b0;
      c_out_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      fresh_q  <= (state_q == RD_ISSUE);
      if (fresh_q) c_out_q <= c_data;
    end
  end

`ifdef ENC_STREAM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Restarts on every state change, so each wait state gets a full budget.
  always_comb begin
    tmo_d = '0;
    if ((state_q == WAIT_KRDY || state_q == WAIT_DONE) && state_d == state_q)
      tmo_d = tmo_q + 1'b1;
  end
  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign busy          = (state_q != IDLE);
  assign err           = err_q;
  assign enc_start     = (state_q == KICK);
  assign key_col_valid = (state_q == STREAM);
  assign c_rd_en       = (state_q == RD_ISSUE);
  assign c_rd_addr     = (state_q == RD_ISSUE) ? idx_q : '0;
  // First hold cycle forwards the fresh memory word; later cycles show the captured copy.
  assign c_out         = fresh_q ? c_data : c_out_q;
  assign c_out_valid   = (state_q == RD_HOLD);

endmodule

// File: tb/tb_enc_stream_ctrl.sv
// Scoreboard bench for enc_stream_ctrl: key memory, ciphertext memory and
// encryptor handshakes are modelled here; expected blocks/words are queued.
module tb_enc_stream_ctrl;
  localparam int NB = 4;
  localparam int CW = 3;
  localparam int TO = 100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, enc_k_ready, enc_done, c_out_ready;
  logic         busy, err, enc_start, key_col_valid, c_rd_en, c_out_valid;
  logic [1:0]   key_addr;
  logic [1:0]   c_rd_addr;
  logic [31:0]  c_data, c_out;
  logic [127:0] key_q;

  logic [127:0] key_sb[$];
  logic [31:0]  c_sb[$];
  int n_chk = 0, n_pass = 0;
  int n_fire = 0, n_enc_start = 0, n_rd_en = 0;
  bit expect_kv_low = 0;

  enc_stream_ctrl #(.NUM_BLOCKS(NB), .COL_WIDTH(128), .CIPHER_WORDS(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .err(err),
    .enc_start(enc_start), .enc_k_ready(enc_k_ready), .enc_done(enc_done),
    .key_addr(key_addr), .key_col_valid(key_col_valid),
    .c_rd_en(c_rd_en), .c_rd_addr(c_rd_addr), .c_data(c_data),
    .c_out(c_out), .c_out_valid(c_out_valid), .c_out_ready(c_out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] kval(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + i;
    return {4{w}};
  endfunction

  // sync-read memories, 1-cycle latency
  always @(posedge clk) begin
    key_q <= kval(int'(key_addr));
    if (c_rd_en) c_data <= 32'hA0 + {30'd0, c_rd_addr};
  end

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (enc_start) n_enc_start++;
      if (c_rd_en)   n_rd_en++;
      if (expect_kv_low) begin
        chk("kv_drop", key_col_valid, 1'b0);
        expect_kv_low = 0;
      end
      if (key_col_valid) begin
        if (key_sb.size() == 0) chk("key_unexp", key_col_valid, 1'b0);
        else if (enc_k_ready) begin
          chk("key_data", key_q, key_sb.pop_front());
          n_fire++;
          if (n_fire == NB) expect_kv_low = 1;
        end else chk("key_hold", key_q, key_sb[0]);
      end
      if (c_out_valid) begin
        if (c_sb.size() == 0) chk("c_unexp", c_out_valid, 1'b0);
        else if (c_out_ready) chk("c_data", c_out, c_sb.pop_front());
        else chk("c_hold", c_out, c_sb[0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic begin_op();
    n_fire = 0; n_enc_start = 0; n_rd_en = 0;
    for (int i = 0; i < NB; i++) key_sb.push_back(kval(i));
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // stream until n fires seen; stall=1 drops ready for 3 cycles after the 2nd fire
  task automatic stream_to(input int n, input bit stall);
    int st = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (n_fire >= n) break;
      if (i < 2) enc_k_ready = 1'b0;
      else if (stall && n_fire >= 2 && st < 3) begin enc_k_ready = 1'b0; st++; end
      else enc_k_ready = 1'b1;
    end
    enc_k_ready = 1'b0;
    chk("fires", n_fire, n);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    chk("idle", busy, 1'b0);
  endtask

  task automatic run_full(input bit stall, input bit rnd);
    begin_op();
    chk("busy_on", busy, 1'b1);
    chk("err_clr", err, 1'b0);
    stream_to(NB, stall);
    repeat (2) tick();
    chk("kv_low", key_col_valid, 1'b0);
    chk("wait_busy", busy, 1'b1);
    for (int i = 0; i < CW; i++) c_sb.push_back(32'hA0 + i);
    enc_done = 1'b1; tick(); enc_done = 1'b0;
    for (int i = 0; i < 100 && busy; i++) begin
      c_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'(i % 2);
      tick();
    end
    c_out_ready = 1'b0;
    chk("done_idle", busy, 1'b0);
    chk("n_rd_en", n_rd_en, CW);
    chk("n_enc_start", n_enc_start, 1);
    chk("err_ok", err, 1'b0);
    chk("key_sb_empty", key_sb.size(), 0);
    chk("c_sb_empty", c_sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; enc_k_ready = 1'b0; enc_done = 1'b0; c_out_ready = 1'b0;
    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_kv", key_col_valid, 1'b0);
    chk("rst_cov", c_out_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // full-throughput stream, then stalled stream with random readout
    run_full(1'b0, 1'b0);
    run_full(1'b1, 1'b1);

    // enc_done mid-stream: error, no readout, next start clears err
    begin_op();
    stream_to(1, 1'b0);
    tick();
    enc_done = 1'b1; tick(); enc_done = 1'b0;
    wait_idle(20);
    chk("abort_err", err, 1'b1);
    chk("abort_rd", n_rd_en, 0);
    key_sb.delete();
    run_full(1'b0, 1'b0);

    // async reset in the middle of the stream
    begin_op();
    stream_to(2, 1'b0);
    tick();
    chk("pre_rst_kv", key_col_valid, 1'b1);
    rst_n = 1'b0; #1;
    chk("ar_busy", busy, 1'b0);
    chk("ar_err", err, 1'b0);
    chk("ar_enc_start", enc_start, 1'b0);
    chk("ar_kaddr", key_addr, 2'd0);
    chk("ar_kv", key_col_valid, 1'b0);
    chk("ar_rd_en", c_rd_en, 1'b0);
    chk("ar_rd_addr", c_rd_addr, 2'd0);
    chk("ar_c_out", c_out, 32'd0);
    chk("ar_cov", c_out_valid, 1'b0);
    tick(); rst_n = 1'b1;
    key_sb.delete(); c_sb.delete();
    n_enc_start = 0; n_rd_en = 0;
    repeat (10) tick();
    chk("post_rst_start", n_enc_start, 0);
    chk("post_rst_rd", n_rd_en, 0);
    chk("post_rst_idle", busy, 1'b0);
    run_full(1'b0, 1'b1);

    // enc_done never arrives
    begin_op();
    stream_to(NB, 1'b0);
`ifdef ENC_STREAM_TIMEOUT_EN
    repeat (TO - 2) tick();
    chk("tmo_early", err, 1'b0);
    tick();
    chk("tmo_hit", err, 1'b1);
    wait_idle(5);
`else
    repeat (150) tick();
    chk("no_tmo_busy", busy, 1'b1);
    chk("no_tmo_err", err, 1'b0);
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    chk("no_tmo_rst", busy, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
